gf_seq_divider: RTL and testbench
=================================

# gf_seq_divider

Sequential bit-serial divider, the inverse of the combinational GF/integer multiplier. It accepts a 2·DATA_WIDTH-bit dividend, such as a multiplier product, and an N-bit divisor. It returns quotient and remainder using either unsigned integer arithmetic or carry-less GF(2) polynomial arithmetic, selected per operation by `gf_option` as in the multiplier. It retires one quotient bit per clock and uses valid/ready handshakes on both sides.

## Interface
- `DATA_WIDTH`, default 32: divisor/remainder width N. The dividend and quotient are 2N bits.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operands valid.
- `in_ready` output, 1: block can accept operands.
- `gf_option` input, 1: 1 = GF(2) polynomial division (XOR); 0 = unsigned integer division. Sampled on accept.
- `dividend` input, 2N: sampled on accept.
- `divisor` input, N: sampled on accept.
- `out_valid` output, 1: result valid.
- `out_ready` input, 1: consumer accepts the result.
- `quotient` output, 2N: quotient.
- `remainder` output, N: remainder.
- `div_by_zero` output, 1: the result came from `divisor == 0`.

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: `in_ready` = 1. `in_valid` latches `gf_option`, dividend, divisor and deg(divisor), clears the partial remainder R (N+1 bits) and the quotient register, and loads the iteration counter with 2N−1.
    - If divisor == 0: go to DONE with quotient = all ones, remainder = dividend[N−1:0], `div_by_zero` = 1.
    - Otherwise go to RUN.
  - RUN: one iteration per cycle. Shift the next dividend bit, MSB first, into R: R' = {R[N−1:0], d}.
    - Integer mode: if R' ≥ {1'b0, divisor} then R = R' − divisor and the quotient bit is 1; else R = R' and the quotient bit is 0.
    - GF mode: if R'[deg] = 1 then R = R' XOR divisor and the quotient bit is 1; else R = R' and the quotient bit is 0.
    - The quotient shifts left with the new bit in the LSB.
    - When the counter reaches 0, go to DONE.
  - DONE: `out_valid` = 1 and outputs are stable. When `out_ready` = 1, return to IDLE.
- `in_ready` is 1 only in IDLE. There is no overlap of operations; `in_valid` in RUN or DONE is ignored.
- Width rules:
  - Integer mode: R < divisor always holds, so the remainder fits in N bits. The quotient can use all 2N bits (e.g. divisor = 1).
  - GF mode: the remainder degree is less than deg(divisor). Bits above deg are always 0.
  - Divisor = 1 in GF mode: deg = 0, quotient = dividend, remainder = 0.
- `remainder` = R[N−1:0]. `div_by_zero` stays 0 for normal results.

## Timing
- Reset (async assert, sync release): state IDLE, `in_ready` = 1, `out_valid` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0, counter 0.
- Handshake at edge T (in_valid & in_ready):
  - RUN occupies cycles T+1 … T+2N.
  - `out_valid` rises after edge T+2N, i.e. it is visible in cycle T+2N+1 with 2N cycles of latency.
- Divide by zero: `out_valid` is visible in the cycle after the accept.
- `out_valid` holds, with outputs unchanged, for any number of cycles until `out_ready`.
- In the cycle where the DONE→IDLE transfer occurs, `in_ready` stays 0. The next accept is possible one cycle later. Minimum throughput is one operation per 2N+2 cycles.
- `out_ready` outside DONE has no effect.
- Reset asserted mid-RUN or mid-DONE aborts immediately to the reset values. The partial result is discarded and no `out_valid` is produced.
- Operand inputs may change freely after the accept cycle.

## Structure
- Shared package `gf_ops_pkg` holds:
  - FSM state enum (IDLE/RUN/DONE).
  - Mode constants GF_MODE = 1'b1, INT_MODE = 1'b0, shared with the multiplier.
  - Function `clog2` for counter width, $clog2(2·DATA_WIDTH).
- One sub-module, `gf_lead_one #(DATA_WIDTH)`: combinational leading-one detector that returns deg(divisor) on $clog2(DATA_WIDTH) bits. It is used once at accept time and its result is registered.
- The datapath is a single shared (N+1)-bit subtract/XOR unit muxed by the latched `gf_option`.

## Test plan
- N=8, integer, dividend 1000 (0x03E8), divisor 7 → quotient 142 (0x008E), remainder 6, `out_valid` exactly 16 cycles after the accept cycle, `div_by_zero` = 0.
- N=8, GF, dividend 0x2B79 (carry-less 0x57·0x83), divisor 0x83 → quotient 0x0057, remainder 0x00. Same with dividend 0x2B7A → quotient 0x0057, remainder 0x03.
- N=8, integer, dividend 0xFFFF, divisor 0x01 → quotient 0xFFFF, remainder 0. In GF mode, the same operands → quotient 0xFFFF, remainder 0.
- Divisor 0, dividend 0x1234 (either mode) → `out_valid` next cycle, quotient 0xFFFF, remainder 0x34, `div_by_zero` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid`.
  - Required: outputs stable, `in_ready` = 0, `in_valid` pulses ignored.
  - After `out_ready` = 1, `in_ready` returns the following cycle.
- Reset pulse at RUN iteration 5 → all outputs at reset values immediately and no `out_valid`. A new op (1000/7, integer) then completes correctly.

Source files
------------

// File: rtl/gf_ops_pkg.sv
// ---------------------------------------------------------------------------
// gf_ops_pkg
// Shared definitions for the GF(2)/integer arithmetic blocks (multiplier and
// sequential divider): divider FSM states, mode encodings and a constant
// ceiling-log2 helper for sizing counters.
// ---------------------------------------------------------------------------
package gf_ops_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // gf_option encodings, identical for multiplier and divider
    localparam logic GF_MODE  = 1'b1;
    localparam logic INT_MODE = 1'b0;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_lead_one.sv
// ---------------------------------------------------------------------------
// gf_lead_one
// Combinational leading-one detector: returns the index of the most
// significant set bit of i_value, i.e. the polynomial degree. An all-zero
// input returns 0 (the divider never uses the result in that case).
//   i_value : DATA_WIDTH-bit operand
//   o_deg   : index of the highest set bit, $clog2(DATA_WIDTH) bits
// ---------------------------------------------------------------------------
module gf_lead_one #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]                                   i_value,
    output logic [((DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1)-1:0] o_deg
);

    localparam int DEG_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Scan upward; the last set bit seen is the most significant one
    always_comb begin
        o_deg = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i_value[i]) o_deg = DEG_W'(i);
        end
    end

endmodule

// File: rtl/gf_seq_divider.sv
// ---------------------------------------------------------------------------
// gf_seq_divider
// Bit-serial restoring divider, one quotient bit per clock. Divides a
// 2N-bit dividend by an N-bit divisor in either unsigned integer or
// carry-less GF(2) polynomial arithmetic, selected per operation.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (in_ready only while idle)
//   gf_option             : 1 = GF(2) division, 0 = unsigned integer
//   dividend [2N-1:0]     : dividend, sampled on accept
//   divisor  [N-1:0]      : divisor, sampled on accept
//   out_valid / out_ready : result handshake, result held until taken
//   quotient [2N-1:0]     : quotient (all ones on divide-by-zero)
//   remainder [N-1:0]     : remainder (dividend low half on divide-by-zero)
//   div_by_zero           : result came from a zero divisor
// ---------------------------------------------------------------------------
module gf_seq_divider
    import gf_ops_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      gf_option,
    input  logic [2*DATA_WIDTH-1:0]   dividend,
    input  logic [DATA_WIDTH-1:0]     divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]     remainder,
    output logic                      div_by_zero
);

    localparam int N     = DATA_WIDTH;
    localparam int DEG_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = clog2(2 * N);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(2 * N - 1);

    div_state_e         r_state;
    logic               r_gf;
    logic [2*N-1:0]     r_dvd;     // dividend, consumed MSB first
    logic [N-1:0]       r_div;
    logic [DEG_W-1:0]   r_deg;
    logic [N-1:0]       r_rem;     // partial remainder; bit N only lives in w_shift
    logic [2*N-1:0]     r_quo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_dbz;

    logic [DEG_W-1:0]   w_deg;
    logic [N:0]         w_shift;
    logic               w_take;
    logic [N-1:0]       w_alu;
    logic [N-1:0]       w_rem_nxt;

    gf_lead_one #(.DATA_WIDTH(N)) u_lead_one (
        .i_value (divisor),
        .o_deg   (w_deg)
    );

    // R' = {R, next dividend bit}
    assign w_shift = {r_rem, r_dvd[2*N-1]};

    // Integer: subtract when R' >= divisor. Result is < divisor, so bit N
    // drops out. GF: reduce when the bit at deg(divisor) is set; XOR
    // clears that bit so the remainder stays below deg.
    assign w_take = (r_gf == GF_MODE) ? w_shift[r_deg]
                                      : (w_shift >= {1'b0, r_div});
    assign w_alu  = (r_gf == GF_MODE) ? (w_shift[N-1:0] ^ r_div)
                                      : (w_shift[N-1:0] - r_div);
    assign w_rem_nxt = w_take ? w_alu : w_shift[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gf        <= INT_MODE;
            r_dvd       <= '0;
            r_div       <= '0;
            r_deg       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_gf       <= gf_option;
                        r_dvd      <= dividend;
                        r_div      <= divisor;
                        r_deg      <= w_deg;
                        r_cnt      <= CNT_INIT;
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_quo       <= '1;
                            r_rem       <= dividend[N-1:0];
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_quo   <= '0;
                            r_rem   <= '0;
                            r_dbz   <= 1'b0;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_dvd <= {r_dvd[2*N-2:0], 1'b0};
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[2*N-2:0], w_take};
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_gf_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_gf_seq_divider
// Directed bench for gf_seq_divider at DATA_WIDTH = 8, with hand-computed
// expected quotients/remainders in integer and GF(2) modes.
// ---------------------------------------------------------------------------
module tb_gf_seq_divider;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           gf_option;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    gf_seq_divider #(.DATA_WIDTH(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gf_option   (gf_option),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic start_op(input logic gf, input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
        int w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        gf_option = gf;
        dividend  = dvd;
        divisor   = dvs;
        tick();                       // accept edge
        in_valid  = 1'b0;
        gf_option = ~gf;              // operands are free to change now
        dividend  = 16'($urandom);
        divisor   = 8'($urandom);
        chk("in_ready_after_accept", in_ready, 0);
    endtask

    // Cycles counted from the accept edge until out_valid is seen
    task automatic wait_result(input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [2*N-1:0] q,
                                input logic [N-1:0] r, input logic dbz);
        chk({tag, "_quotient"}, quotient, q);
        chk({tag, "_remainder"}, remainder, r);
        chk({tag, "_dbz"}, div_by_zero, dbz);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        #0;
        chk("in_ready_low_on_release", in_ready, 0);
        tick();
        out_ready = 1'b0;
        chk("out_valid_dropped", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic gf, input logic [2*N-1:0] dvd,
                          input logic [N-1:0] dvs, input int lat,
                          input logic [2*N-1:0] q, input logic [N-1:0] r, input logic dbz);
        start_op(gf, dvd, dvs);
        wait_result(lat);
        check_result(tag, q, r, dbz);
        release_result();
    endtask

    initial begin
        logic [2*N-1:0] held_q;
        logic [N-1:0]   held_r;
        bit             stray_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gf_option = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1000 / 7 = 142 r 6
        run_op("int_1000_7", 1'b0, 16'h03E8, 8'h07, 16, 16'h008E, 8'h06, 1'b0);
        // carry-less 0x57*0x83 = 0x2B79
        run_op("gf_exact", 1'b1, 16'h2B79, 8'h83, 16, 16'h0057, 8'h00, 1'b0);
        run_op("gf_rem3", 1'b1, 16'h2B7A, 8'h83, 16, 16'h0057, 8'h03, 1'b0);
        run_op("int_div1", 1'b0, 16'hFFFF, 8'h01, 16, 16'hFFFF, 8'h00, 1'b0);
        run_op("gf_div1", 1'b1, 16'hFFFF, 8'h01, 16, 16'hFFFF, 8'h00, 1'b0);
        // 0xFFFF / 0xFF = 0x101 r 0 (integer)
        run_op("int_ff", 1'b0, 16'hFFFF, 8'hFF, 16, 16'h0101, 8'h00, 1'b0);
        // x^15 / x^7 in GF: quotient x^8, remainder 0
        run_op("gf_x15", 1'b1, 16'h8000, 8'h80, 16, 16'h0100, 8'h00, 1'b0);
        run_op("int_dbz", 1'b0, 16'h1234, 8'h00, 0, 16'hFFFF, 8'h34, 1'b1);
        run_op("gf_dbz", 1'b1, 16'h1234, 8'h00, 0, 16'hFFFF, 8'h34, 1'b1);
        // normal op after divide-by-zero clears the flag: 200/13 = 15 r 5
        run_op("int_200_13", 1'b0, 16'h00C8, 8'h0D, 16, 16'h000F, 8'h05, 1'b0);

        // Backpressure: hold result 5 cycles while pulsing in_valid
        start_op(1'b0, 16'h00C8, 8'h0D);
        wait_result(16);
        held_q = 16'h000F;
        held_r = 8'h05;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            gf_option = 1'b1;
            dividend  = 16'h1111 * 16'(i + 1);
            divisor   = 8'(i);
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_quotient", quotient, held_q);
            chk("bp_remainder", remainder, held_r);
            chk("bp_dbz", div_by_zero, 0);
        end
        in_valid = 1'b0;
        release_result();

        // Reset during RUN, iteration 5
        start_op(1'b0, 16'h03E8, 8'h07);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) stray_valid = 1'b1;
        end
        chk("midrst_no_out_valid", stray_valid, 0);
        run_op("int_after_rst", 1'b0, 16'h03E8, 8'h07, 16, 16'h008E, 8'h06, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
